// File: rtl/lz4_pkg.sv
// Shared types and constants for the LZ4 block feeder.
// Optional checksum skipping is enabled with LZ4_BLOCK_CHECKSUM_EN.
package lz4_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_PAY,
        S_CSUM,
        S_END,
        S_ERR
    } state_t;

    localparam int HDR_BYTES  = 4;
    localparam int CSUM_BYTES = 4;
    localparam int RAW_BIT    = 31;

    // Bits needed to hold any legal block length, including the maximum.
    function automatic int cnt_width(input int max_size);
        return $clog2(max_size + 1);
    endfunction

endpackage

// File: rtl/lz4_byte_fifo.sv
// Small payload FIFO with a registered head/valid output stage.
// Pop happens whenever data is present and the consumer is ready.
module lz4_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             out_ready,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;
    logic             push_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = !empty && out_ready;
    assign push_ok = push && !full;

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Registered head: the popped byte is presented for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= pop;
            if (pop) dout <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/lz4_block_feeder.sv
// Parses LZ4 block-size headers and forwards payload bytes only.
// Define LZ4_BLOCK_CHECKSUM_EN to skip a 4-byte checksum per block.
module lz4_block_feeder
    import lz4_pkg::*;
#(
    parameter int WORD_SIZE      = 8,
    parameter int MAX_BLOCK_SIZE = 65536,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] compressed_word,
    output logic                 write,
    input  logic                 out_ready,
    output logic                 blk_raw,
    output logic                 block_start,
    output logic                 block_done,
    output logic                 frame_end,
    output logic                 error
);

    localparam int          CW      = cnt_width(MAX_BLOCK_SIZE);
    localparam logic [31:0] MAX_LEN = 32'(MAX_BLOCK_SIZE);

    state_t        state;
    state_t        state_nx;
    logic [1:0]    idx;
    logic [23:0]   hdr_lo;
    logic [31:0]   hdr_word;
    logic [30:0]   len;
    logic          raw_b;
    logic          len_zero;
    logic          len_big;
    logic [CW-1:0] remaining;
    logic          accept;
    logic          hdr_last;
    logic          pay_last;
    logic          push;
    logic          full;
    logic          empty;
    logic          ev_load;
    logic          ev_start;
    logic          ev_done;
    logic          ev_end;
    logic          ev_err;
`ifdef LZ4_BLOCK_CHECKSUM_EN
    logic          csum_last;
`endif

    // The fourth header byte is still on in_byte when the header completes.
    assign hdr_word = {in_byte[7:0], hdr_lo};
    assign len      = hdr_word[30:0];
    assign raw_b    = hdr_word[RAW_BIT];
    assign len_zero = (len == '0);
    assign len_big  = ({1'b0, len} > MAX_LEN);

    assign accept   = in_valid && in_ready;
    assign hdr_last = accept && (state == S_HDR)
                      && (idx == 2'(HDR_BYTES - 1));
    assign pay_last = accept && (state == S_PAY)
                      && (remaining == CW'(1));
    assign push     = accept && (state == S_PAY);
`ifdef LZ4_BLOCK_CHECKSUM_EN
    assign csum_last = accept && (state == S_CSUM)
                       && (idx == 2'(CSUM_BYTES - 1));
`endif

    assign ev_end   = hdr_last && len_zero && !raw_b;
    assign ev_err   = hdr_last && len_big;
    assign ev_load  = hdr_last && !len_zero && !len_big;
    assign ev_start = ev_load || (hdr_last && len_zero && raw_b);
    assign ev_done  = pay_last || (hdr_last && len_zero && raw_b);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_HDR;
        else        state <= state_nx;
    end

    // Next-state decode from the completed header or payload count.
    always_comb begin
        state_nx = state;
        case (state)
            S_HDR: begin
                if (ev_end)       state_nx = S_END;
                else if (ev_err)  state_nx = S_ERR;
                else if (ev_load) state_nx = S_PAY;
            end
            S_PAY: begin
`ifdef LZ4_BLOCK_CHECKSUM_EN
                if (pay_last) state_nx = S_CSUM;
`else
                if (pay_last) state_nx = S_HDR;
`endif
            end
`ifdef LZ4_BLOCK_CHECKSUM_EN
            S_CSUM: begin
                if (csum_last) state_nx = S_HDR;
            end
`endif
            default: ;
        endcase
    end

    // Input-side ready; a full FIFO stalls payload even if it pops now.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_HDR:   in_ready = reset;
            S_PAY:   in_ready = reset && !full;
`ifdef LZ4_BLOCK_CHECKSUM_EN
            S_CSUM:  in_ready = reset;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    // Header capture, length counter, status flags and event pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            hdr_lo      <= '0;
            remaining   <= '0;
            blk_raw     <= 1'b0;
            block_start <= 1'b0;
            block_done  <= 1'b0;
            frame_end   <= 1'b0;
            error       <= 1'b0;
        end else begin
            block_start <= ev_start;
            block_done  <= ev_done;
            frame_end   <= ev_end;
            if (ev_err) error <= 1'b1;
            if (accept && state == S_HDR) begin
                idx    <= idx + 1'b1;
                hdr_lo <= {in_byte[7:0], hdr_lo[23:8]};
            end
`ifdef LZ4_BLOCK_CHECKSUM_EN
            if (accept && state == S_CSUM) idx <= idx + 1'b1;
`endif
            if (ev_load) begin
                remaining <= len[CW-1:0];
                blk_raw   <= raw_b;
            end else if (push) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

    lz4_byte_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .din        (in_byte),
        .out_ready  (out_ready),
        .full       (full),
        .empty      (empty),
        .dout       (compressed_word),
        .dout_valid (write)
    );

    logic unused_ok;
    assign unused_ok = empty;

endmodule

// File: doc/lz4_block_feeder.md
Name: lz4_block_feeder

Overview:
- Upstream stage of the LZ4 decompressor.
- Accepts a raw LZ4 frame-body byte stream with a valid/ready handshake and parses each 4-byte little-endian block-size header.
- Forwards only block payload bytes to the decompressor's compressed_word/write inputs through a small internal FIFO.
- Reports block boundaries, the end mark and size errors.

Parameters:
- WORD_SIZE, 8, byte width of the input and output data.
- MAX_BLOCK_SIZE, 65536, largest legal block length in bytes; a larger length is an error.
- FIFO_DEPTH, 4, payload FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_byte  in  WORD_SIZE  frame-body byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  block accepts in_byte this cycle.
- compressed_word  out  WORD_SIZE  payload byte to the decompressor.
- write  out  1  compressed_word is valid; the byte is consumed in this cycle.
- out_ready  in  1  decompressor can take a byte; tie to 1 if unused.
- blk_raw  out  1  current block is stored uncompressed (header bit 31).
- block_start  out  1  one-cycle pulse when a valid header completes.
- block_done  out  1  one-cycle pulse when the last payload byte is accepted.
- frame_end  out  1  one-cycle pulse when the end mark is accepted.
- error  out  1  sticky size error.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_HDR, header byte index=0, FIFO empty.
  - All outputs 0; compressed_word=0.
- Input handshake: a byte transfers on a rising clk edge with in_valid & in_ready. in_byte must be held until accepted.
- in_ready:
  - 1 in S_HDR and S_CSUM.
  - 1 in S_PAY when the FIFO is not full. A same-cycle pop does not free space for a push.
  - 0 in S_END and S_ERR.
- S_HDR:
  - Collect 4 bytes, least significant first, into a 32-bit header register.
  - On the 4th byte: len=hdr[30:0], raw=hdr[31].
  - len=0 and raw=0 -> pulse frame_end, go to S_END.
  - len=0 and raw=1 -> pulse block_start and block_done in the same cycle, stay in S_HDR.
  - len>MAX_BLOCK_SIZE -> error=1, go to S_ERR.
  - Otherwise -> pulse block_start, blk_raw<=raw, load remaining<=len, go to S_PAY.
- S_PAY:
  - Each accepted byte is pushed into the FIFO and decrements remaining.
  - On the byte taking remaining from 1 to 0: pulse block_done, go to S_CSUM if LZ4_BLOCK_CHECKSUM_EN is defined, else S_HDR.
- S_END: idle until reset; the FIFO still drains.
- S_ERR: error stays 1 until reset; in_ready=0; the FIFO still drains.
- Output side:
  - write = FIFO not empty & out_ready; compressed_word = FIFO head, registered.
  - Latency: a byte accepted at edge N can appear with write=1 in the cycle after edge N+1. This holds for an empty FIFO with out_ready=1.
  - When write=0, compressed_word holds its last value.
- Header and checksum bytes never enter the FIFO.
- blk_raw holds until the next header completes.
- Counter width is $clog2(MAX_BLOCK_SIZE+1). Header comparison uses the full 31-bit len before truncation.
- Simultaneous events: a FIFO push and pop in the same cycle are both performed, and occupancy is unchanged.
- A reset in mid-block discards the FIFO contents and the partial header.

Optional Feature:
- Macro: LZ4_BLOCK_CHECKSUM_EN.
- Defined: after each non-empty block, S_CSUM accepts exactly 4 more bytes (the block checksum), discards them and returns to S_HDR. block_done still pulses on the last payload byte. Zero-length raw blocks carry no checksum.
- Undefined: the S_CSUM state and its logic are absent; the next header follows the payload directly.

Decomposition:
- Package lz4_pkg:
  - state enum (S_HDR, S_PAY, S_CSUM, S_END, S_ERR).
  - HDR_BYTES=4, CSUM_BYTES=4, RAW_BIT=31.
  - Shared function for the remaining-counter width.
- One sub-module: lz4_byte_fifo.
  - Synchronous push/pop, full/empty flags, registered head output.
  - Same clk and active-low asynchronous reset.

Test Plan:
- Header 14 00 00 00, then 20 payload bytes f0 02 30..39 61..67 00, then end mark 00 00 00 00, out_ready=1 -> the 20 bytes appear on compressed_word with write=1 in order; block_start and block_done pulse once each; blk_raw=0; frame_end pulses; in_ready=0 afterwards.
- Same frame with out_ready held 0 for 10 cycles mid-block -> in_ready falls after FIFO_DEPTH payload bytes; no byte is lost or duplicated after out_ready returns to 1.
- Header 05 00 00 80 followed by 41 42 43 44 45 -> blk_raw=1; 41..45 forwarded; block_done on the byte 45.
- Header 00 00 00 80, then header 02 00 00 00 and 11 22 -> the first header pulses block_start and block_done together; 11 22 forwarded.
- Header 01 00 01 00 (65537 > MAX) -> error=1 and in_ready=0; error remains 1 after 100 idle cycles; reset (reset=0) clears it.
- LZ4_BLOCK_CHECKSUM_EN defined: header 02 00 00 00, AA BB, checksum 01 02 03 04, end mark -> only AA BB forwarded; frame_end pulses.
